// File: rtl/lock_unlock_ctrl.sv
// Two-word software unlock sequencer for the power-on lock register, with failed-attempt lockout.
// Define LOCK_UNLOCK_TIMEOUT_EN to bound the wait for KEY1 to TIMEOUT_CYCLES cycles.
module lock_unlock_ctrl #(
  parameter logic [15:0] KEY0           = 16'hA5A5,
  parameter logic [15:0] KEY1           = 16'h5A5A,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        locked_in,
  output logic        unlock,
  output logic [3:0]  fail_count,
  output logic        key_pending,
  output logic        lockout
);

  if (MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_bad_max_fail
    $error("MAX_FAIL must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  localparam logic [3:0] MAX_FAIL_W = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_KEY1,
    ST_PULSE,
    ST_DONE,
    ST_LOCKOUT
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_fail_count;
  logic [3:0] w_fail_count_next;
  logic       w_xfer;
  logic       w_fail;
  logic       w_expired;

`ifdef LOCK_UNLOCK_TIMEOUT_EN
  logic [15:0] r_to_count;

  // Counter reads 0 on the first WAIT_KEY1 cycle, so TIMEOUT_CYCLES-1 marks the last one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_to_count <= '0;
    end else if (r_state != ST_WAIT_KEY1) begin
      r_to_count <= '0;
    end else begin
      r_to_count <= r_to_count + 16'd1;
    end
  end

  assign w_expired = (r_state == ST_WAIT_KEY1) && (r_to_count == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_expired = 1'b0;
`endif

  assign wr_ready    = (r_state == ST_IDLE) || (r_state == ST_WAIT_KEY1) || (r_state == ST_DONE);
  assign w_xfer      = wr_valid && wr_ready;
  assign unlock      = (r_state == ST_PULSE);
  assign key_pending = (r_state == ST_WAIT_KEY1);
  assign lockout     = (r_state == ST_LOCKOUT);
  assign fail_count  = r_fail_count;

  always_comb begin
    w_state_next      = r_state;
    w_fail_count_next = r_fail_count;
    w_fail            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // An already-unlocked register needs no key sequence.
        if (!locked_in) begin
          w_state_next = ST_DONE;
        end else if (w_xfer) begin
          if (wr_data == KEY0) begin
            w_state_next = ST_WAIT_KEY1;
          end else begin
            w_fail = 1'b1;
          end
        end
      end
      ST_WAIT_KEY1: begin
        if (w_xfer) begin
          if (wr_data == KEY1) begin
            w_state_next      = ST_PULSE;
            w_fail_count_next = '0;
          end else begin
            w_fail = 1'b1;
          end
        end else if (w_expired) begin
          w_fail = 1'b1;
        end
      end
      ST_PULSE:   w_state_next = ST_DONE;
      ST_DONE: begin
        if (locked_in) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_LOCKOUT: w_state_next = ST_LOCKOUT;
      default:    w_state_next = ST_IDLE;
    endcase

    // Outside LOCKOUT the count is below MAX_FAIL, so the increment cannot wrap.
    if (w_fail) begin
      w_fail_count_next = r_fail_count + 4'd1;
      w_state_next      = (w_fail_count_next == MAX_FAIL_W) ? ST_LOCKOUT : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_fail_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_fail_count <= w_fail_count_next;
    end
  end

endmodule

// File: tb/tb_lock_unlock_ctrl.sv
// Directed bench for lock_unlock_ctrl: a flag-based model of the unlock protocol is checked
// against the DUT every cycle, plus literal expectations for the key scenarios.
module tb_lock_unlock_ctrl;

  localparam logic [15:0] KEY0     = 16'hA5A5;
  localparam logic [15:0] KEY1     = 16'h5A5A;
  localparam int          MAX_FAIL = 3;
  localparam int          TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        locked_in;
  logic        unlock;
  logic [3:0]  fail_count;
  logic        key_pending;
  logic        lockout;
  logic        set_lock;
  logic        clr_lock;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  // Protocol model: flags describe where the unlock attempt stands.
  bit m_armed, m_fire, m_open, m_locked_out;
  int m_fails, m_wait;

  lock_unlock_ctrl #(
    .KEY0(KEY0), .KEY1(KEY1), .MAX_FAIL(MAX_FAIL), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .locked_in(locked_in), .unlock(unlock),
    .fail_count(fail_count), .key_pending(key_pending), .lockout(lockout)
  );

  always #5 clk = ~clk;

  // The external power-on lock register: cleared by unlock, set/cleared by the bench.
  always @(posedge clk) begin
    if (unlock)        locked_in <= 1'b0;
    else if (set_lock) locked_in <= 1'b1;
    else if (clr_lock) locked_in <= 1'b0;
  end

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_armed = 0; m_fire = 0; m_open = 0; m_locked_out = 0; m_fails = 0; m_wait = 0;
  endfunction

  function automatic void model_fail();
    m_fails++;
    m_armed = 0;
    if (m_fails == MAX_FAIL) m_locked_out = 1;
  endfunction

  function automatic void model_step(bit v, logic [15:0] d, bit lk);
    bit xfer;
    xfer = v && !(m_fire || m_locked_out);
    if (m_locked_out) begin
    end else if (m_fire) begin
      m_fire = 0;
      m_open = 1;
    end else if (m_open) begin
      if (lk) m_open = 0;
    end else if (m_armed) begin
      if (xfer) begin
        if (d == KEY1) begin
          m_armed = 0; m_fire = 1; m_fails = 0;
        end else begin
          model_fail();
        end
      end
`ifdef LOCK_UNLOCK_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TIMEOUT) model_fail();
      end
`endif
    end else begin
      if (!lk) m_open = 1;
      else if (xfer) begin
        if (d == KEY0) begin
          m_armed = 1; m_wait = 0;
        end else begin
          model_fail();
        end
      end
    end
  endfunction

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit v, lk;
    logic [15:0] d;
    @(negedge clk);
    chk("wr_ready",    int'(wr_ready),    int'(!(m_fire || m_locked_out)));
    chk("unlock",      int'(unlock),      int'(m_fire));
    chk("key_pending", int'(key_pending), int'(m_armed));
    chk("lockout",     int'(lockout),     int'(m_locked_out));
    chk("fail_count",  int'(fail_count),  m_fails);
    if (unlock === 1'b1) pulses++;
    v = wr_valid; d = wr_data; lk = locked_in;
    @(posedge clk);
    if (resetn) model_step(v, d, lk);
    #1;
  endtask

  task automatic wr(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    model_reset();
    repeat (n) tick();
    resetn = 1'b1;
  endtask

  task automatic relock();
    set_lock = 1'b1;
    tick();
    set_lock = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0; wr_valid = 1'b0; wr_data = '0; set_lock = 1'b1; clr_lock = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset(3);
    set_lock = 1'b0;
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_fail_count", int'(fail_count), 0);
    chk("rst_lockout", int'(lockout), 0);
    $display("reset done: wr_ready=%0d fail_count=%0d", wr_ready, fail_count);

    // Back-to-back key pair produces one unlock pulse on the cycle after KEY1.
    wr(KEY0);
    chk("pair_pending", int'(key_pending), 1);
    wr(KEY1);
    chk("pair_unlock", int'(unlock), 1);
    tick();
    chk("pair_unlock_end", int'(unlock), 0);
    chk("pair_fails", int'(fail_count), 0);
    chk("pair_done_ready", int'(wr_ready), 1);
    chk("pair_pulses", pulses, 1);
    $display("key pair: pulses=%0d fail_count=%0d", pulses, fail_count);
    relock();

    // One failure, then a good pair clears the count.
    wr(16'h1234);
    chk("fail1_count", int'(fail_count), 1);
    wr(KEY0);
    wr(KEY1);
    chk("recover_unlock", int'(unlock), 1);
    chk("recover_fails", int'(fail_count), 0);
    tick();
    chk("recover_pulses", pulses, 2);
    $display("fail then pair: pulses=%0d fail_count=%0d", pulses, fail_count);
    relock();

    // Three bad writes lock the controller out.
    for (int i = 1; i <= 3; i++) begin
      wr(16'h1234);
      chk("lock_seq_count", int'(fail_count), i);
      $display("bad write %0d: fail_count=%0d lockout=%0d", i, fail_count, lockout);
    end
    chk("lockout_flag", int'(lockout), 1);
    chk("lockout_ready", int'(wr_ready), 0);
    wr(KEY0);
    wr(KEY1);
    tick(); tick();
    chk("lockout_no_pulse", pulses, 2);
    chk("lockout_hold", int'(fail_count), 3);
    do_reset(2);
    chk("lockout_cleared", int'(lockout), 0);
    chk("lockout_cnt_cleared", int'(fail_count), 0);
    $display("lockout exit by reset: lockout=%0d", lockout);

    // Reset while waiting for KEY1 aborts the sequence.
    wr(KEY0);
    do_reset(1);
    wr(KEY1);
    tick();
    chk("abort_fails", int'(fail_count), 1);
    chk("abort_pulses", pulses, 2);
    $display("reset mid-sequence: fail_count=%0d pulses=%0d", fail_count, pulses);
    do_reset(1);

    // Near-miss words never match.
    wr(KEY0);
    wr(16'h5A5B);
    chk("nearkey1_fail", int'(fail_count), 1);
    chk("nearkey1_pending", int'(key_pending), 0);
    wr(16'hA5A4);
    chk("nearkey0_fail", int'(fail_count), 2);
    $display("near-miss keys: fail_count=%0d", fail_count);
    do_reset(1);

    // Already unlocked: IDLE goes to DONE, writes are ignored.
    clr_lock = 1'b1;
    tick();
    clr_lock = 1'b0;
    tick();
    wr(16'h1234);
    chk("done_ignore_fails", int'(fail_count), 0);
    chk("done_ignore_pending", int'(key_pending), 0);
    $display("unlocked idle: fail_count=%0d", fail_count);
    relock();

`ifdef LOCK_UNLOCK_TIMEOUT_EN
    wr(KEY0);
    repeat (TIMEOUT - 1) tick();
    chk("to_still_pending", int'(key_pending), 1);
    tick();
    chk("to_expired_pending", int'(key_pending), 0);
    chk("to_expired_fails", int'(fail_count), 1);
    wr(KEY0);
    repeat (TIMEOUT - 1) tick();
    wr(KEY1);
    chk("to_last_cycle_unlock", int'(unlock), 1);
    chk("to_last_cycle_fails", int'(fail_count), 0);
    $display("timeout: unlock=%0d fail_count=%0d", unlock, fail_count);
`else
    wr(KEY0);
    repeat (1000) tick();
    chk("long_wait_pending", int'(key_pending), 1);
    wr(KEY1);
    chk("long_wait_unlock", int'(unlock), 1);
    $display("long wait: unlock=%0d", unlock);
`endif
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
